// File: rtl/gen_regfile_sb.sv
// Parametrised register file (reg 0 hardwired to zero) with two bypassed read ports,
// one write port and a per-register pending scoreboard for RAW hazard detection.
module gen_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  output logic            busy1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic            any_busy
);

  logic [XLEN-1:0] r_regs [1:NREG-1];
  logic [XLEN-1:0] w_rf   [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_next;
  logic [NREG-1:1] w_wr_sel;
  logic            w_hit1;
  logic            w_hit2;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_rf[gi]        = '0;
        assign w_pend_next[gi] = 1'b0;
      end else begin : g_live
        assign w_wr_sel[gi] = we && (wa == AW'(gi));
        assign w_rf[gi]     = r_regs[gi];

        // Flush beats issue; issue (younger producer) beats a same-cycle writeback.
        always_comb begin
          w_pend_next[gi] = r_pend[gi];
          if (flush)
            w_pend_next[gi] = 1'b0;
          else if (iss_valid && (iss_rd == AW'(gi)))
            w_pend_next[gi] = 1'b1;
          else if (w_wr_sel[gi])
            w_pend_next[gi] = 1'b0;
        end

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn)
            r_regs[gi] <= '0;
          else if (w_wr_sel[gi])
            r_regs[gi] <= wd;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_pend <= '0;
    else
      r_pend <= w_pend_next;
  end

  // A writeback to the address being read is forwarded and also resolves its hazard.
  assign w_hit1 = we && (wa == ra1);
  assign w_hit2 = we && (wa == ra2);

  always_comb begin
    rd1 = w_rf[ra1];
    if (ra1 == '0)
      rd1 = '0;
    else if (w_hit1)
      rd1 = wd;
  end

  always_comb begin
    rd2 = w_rf[ra2];
    if (ra2 == '0)
      rd2 = '0;
    else if (w_hit2)
      rd2 = wd;
  end

  assign busy1    = r_pend[ra1] & ~w_hit1;
  assign busy2    = r_pend[ra2] & ~w_hit2;
  assign any_busy = |r_pend;

endmodule

// File: doc/gen_regfile_sb.md
Name: gen_regfile_sb

Overview:
Parametrised successor to the fixed 16x32 general register file. Provides NREG registers of XLEN bits with register 0 hardwired to zero. Has two combinational read ports with write-through bypass and one synchronous write port. Adds a per-register pending scoreboard so the decode stage can detect RAW hazards against in-flight writebacks. It sits between decode (read and issue) and writeback (write and clear).

Parameters:
XLEN, 32, data width of each register
NREG, 16, number of registers; power of two, >= 2
AW, $clog2(NREG), register address width (derived; not overridden)

Ports:
clk  in  1  system clock; all state updates on rising edge
rstn  in  1  asynchronous active-low reset
ra1  in  AW  read port 1 address
rd1  out  XLEN  read port 1 data
busy1  out  1  register ra1 has a pending write
ra2  in  AW  read port 2 address
rd2  out  XLEN  read port 2 data
busy2  out  1  register ra2 has a pending write
we  in  1  writeback enable
wa  in  AW  writeback address
wd  in  XLEN  writeback data
iss_valid  in  1  an instruction writing iss_rd is issued this cycle
iss_rd  in  AW  destination of issued instruction
flush  in  1  clear all pending bits (pipeline flush)
any_busy  out  1  OR of all pending bits

Behaviour:
- Reset (rstn low, asynchronous): registers 1..NREG-1 are cleared to 0 and all pending bits to 0 immediately, without waiting for a clock. Outputs follow from that: rd1/rd2 = 0, busy1/busy2 = 0, any_busy = 0.
- Register 0: reads always return 0 and its pending bit always reads 0. Writes and issues to address 0 are ignored.
- Write: when we = 1 and wa != 0, reg[wa] <= wd at the rising edge.
- Read (combinational, zero latency): rdN = 0 if raN == 0. Otherwise rdN = wd if we = 1 and wa == raN (write-through bypass). Otherwise rdN = reg[raN].
- Pending bit p[i], i != 0, next-state priority at each edge:
  1. flush = 1 -> p[i] <= 0 for all i, even if iss_valid is high the same cycle.
  2. iss_valid = 1 and iss_rd == i -> p[i] <= 1. Set wins over a same-cycle writeback to the same register, because the new producer is younger.
  3. we = 1 and wa == i -> p[i] <= 0.
  4. Otherwise p[i] holds.
- Flush affects only pending bits. A write with we = 1 in a flush cycle still updates reg[wa].
- busyN = p[raN] & ~(we & (wa == raN)). A same-cycle writeback resolves the hazard combinationally, consistent with the bypass.
- any_busy = |p, registered-state based with no bypass term.
- Writeback to a register whose pending bit is 0 is legal: data is written and p stays 0.
- Issue to a register whose pending bit is already 1 is legal: p stays 1. A single bit is kept; there is no counting of outstanding writes.
- Reset deasserted mid-operation: the first edge after release behaves as from a clean reset state. Inputs present during reset have no effect.
- No X propagation: out-of-range addresses are impossible because NREG = 2^AW.

Test Plan:
1. Reset with rstn = 0 and no clk edge -> rd1 = rd2 = 0 for any address, any_busy = 0 immediately.
2. Write: we = 1, wa = 5, wd = 0xDEADBEEF, one edge, then we = 0 and ra1 = 5 -> rd1 = 0xDEADBEEF. Write wa = 0, wd = 0x1234, then ra2 = 0 -> rd2 = 0.
3. Bypass: reg[3] = 0x11, we = 1, wa = 3, wd = 0x22, ra1 = 3 in the same cycle -> rd1 = 0x22 before the edge, and 0x22 after the edge with we = 0.
4. Scoreboard: iss_valid = 1, iss_rd = 7, edge -> busy1 = 1 with ra1 = 7, any_busy = 1. Then we = 1, wa = 7 -> busy1 = 0 combinationally, and p[7] = 0 after the edge.
5. Simultaneous events:
   - p[4] = 1; iss_valid with iss_rd = 4 and we with wa = 4 in the same cycle -> p[4] = 1 after the edge, reg[4] = wd.
   - p[2] = p[9] = 1; flush = 1 with iss_valid, iss_rd = 2 -> all p = 0, any_busy = 0.
6. Mid-operation reset: p[6] = 1 and reg[6] = 0xA5, pulse rstn low between edges -> any_busy = 0 and reg[6] reads 0 with no clock edge. Repeat with XLEN = 64 and NREG = 32: write reg[31] = 0xFFFF_FFFF_0000_0001 -> reads back exactly.
